// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter that owns the shared account balance and serializes
// inquiry / deposit / withdraw transactions from N_REQ terminal session FSMs.
module atm_ledger_arbiter #(
  parameter int unsigned      N_REQ    = 4,
  parameter int unsigned      BAL_W    = 32,
  parameter int unsigned      AMT_W    = 16,
  parameter logic [BAL_W-1:0] INIT_BAL = BAL_W'(32'h000F4240)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [2*N_REQ-1:0]     op_i,
  input  logic [AMT_W*N_REQ-1:0] amt_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   done_o,
  output logic [1:0]             status_o,
  output logic [BAL_W-1:0]       balance_out_o,
  output logic                   busy_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_INQ = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;
  localparam logic [1:0] OP_WDR = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_BAD   = 2'b11;

  // EVAL registers the arithmetic result one cycle ahead of the commit edge,
  // keeping the wide add/compare off the commit path.
  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_EXEC,
    S_RESP
  } state_e;

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic               done_q;
  logic [1:0]         status_q;
  logic [BAL_W-1:0]   bal_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   own_q;
  logic [1:0]         op_q;
  logic [AMT_W-1:0]   amt_q;
  logic [1:0]         res_status_q;
  logic [BAL_W-1:0]   res_bal_q;

  logic               win_found_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic [1:0]         win_op_c;
  logic [AMT_W-1:0]   win_amt_c;
  logic [PTR_W-1:0]   ptr_next_c;
  int unsigned        cand_c;

  logic [BAL_W-1:0]   amt_ext_c;
  logic [BAL_W:0]     sum_c;
  logic [1:0]         res_status_c;
  logic [BAL_W-1:0]   res_bal_c;

  // Round-robin search upward from the pointer, wrapping at N_REQ-1.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_op_c    = '0;
    win_amt_c   = '0;
    cand_c      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_c = 32'(ptr_q) + i;
      if (cand_c >= N_REQ) begin
        cand_c = cand_c - N_REQ;
      end
      if (!win_found_c && req_i[PTR_W'(cand_c)]) begin
        win_found_c = 1'b1;
        win_idx_c   = PTR_W'(cand_c);
        win_op_c    = op_i[2*cand_c +: 2];
        win_amt_c   = amt_i[AMT_W*cand_c +: AMT_W];
      end
    end
    ptr_next_c = (win_idx_c == PTR_W'(N_REQ-1)) ? '0 : win_idx_c + 1'b1;
  end

  // Transaction result on the latched opcode and amount.
  always_comb begin
    amt_ext_c    = BAL_W'(amt_q);
    sum_c        = {1'b0, bal_q} + {1'b0, amt_ext_c};
    res_status_c = ST_OK;
    res_bal_c    = bal_q;
    case (op_q)
      OP_INQ: begin
        res_status_c = ST_OK;
      end
      OP_DEP: begin
        if (sum_c[BAL_W]) begin
          res_status_c = ST_OVF;
        end else begin
          res_bal_c = sum_c[BAL_W-1:0];
        end
      end
      OP_WDR: begin
        if (amt_ext_c > bal_q) begin
          res_status_c = ST_INSUF;
        end else begin
          res_bal_c = bal_q - amt_ext_c;
        end
      end
      default: begin
        res_status_c = ST_BAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      done_q       <= 1'b0;
      status_q     <= ST_OK;
      bal_q        <= INIT_BAL;
      busy_q       <= 1'b0;
      ptr_q        <= '0;
      own_q        <= '0;
      op_q         <= '0;
      amt_q        <= '0;
      res_status_q <= ST_OK;
      res_bal_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_c) begin
            grant_q <= N_REQ'(1) << win_idx_c;
            own_q   <= win_idx_c;
            op_q    <= win_op_c;
            amt_q   <= win_amt_c;
            ptr_q   <= ptr_next_c;
            busy_q  <= 1'b1;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          res_status_q <= res_status_c;
          res_bal_q    <= res_bal_c;
          state_q      <= S_EXEC;
        end
        S_EXEC: begin
          bal_q    <= res_bal_q;
          status_q <= res_status_q;
          done_q   <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          done_q <= 1'b0;
          if (!req_i[own_q]) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign balance_out_o = bal_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed self-checking bench for atm_ledger_arbiter; a second instance
// starts near the top of the balance range to reach the overflow boundary.
module tb_atm_ledger_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [63:0] amt;
  logic [3:0]  grant;
  logic        done;
  logic [1:0]  status;
  logic [31:0] bal;
  logic        busy;

  logic [3:0]  req2;
  logic [7:0]  op2;
  logic [63:0] amt2;
  logic [3:0]  grant2;
  logic        done2;
  logic [1:0]  status2;
  logic [31:0] bal2;
  logic        busy2;

  int errors;
  int checks;

  atm_ledger_arbiter dut (
    .clk(clk), .reset(reset), .req_i(req), .op_i(op), .amt_i(amt),
    .grant_o(grant), .done_o(done), .status_o(status),
    .balance_out_o(bal), .busy_o(busy)
  );

  atm_ledger_arbiter #(.INIT_BAL(32'hFFFF_FFF0)) dut_hi (
    .clk(clk), .reset(reset), .req_i(req2), .op_i(op2), .amt_i(amt2),
    .grant_o(grant2), .done_o(done2), .status_o(status2),
    .balance_out_o(bal2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_term(input int t, input logic r, input logic [1:0] o, input logic [15:0] a);
    req[t]          = r;
    op[2*t +: 2]    = o;
    amt[16*t +: 16] = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    req2  = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One transaction on the main instance with the winner dropping req after done.
  task automatic txn(input string tag, input int t, input logic [1:0] o, input logic [15:0] a,
                     input logic [1:0] es, input logic [31:0] eb);
    logic [3:0] eg;
    eg = 4'(1) << t;
    set_term(t, 1'b1, o, a);
    tick();
    chk({tag, ".grant"}, 64'(grant), 64'(eg));
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    tick();
    tick();
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".status"}, 64'(status), 64'(es));
    chk({tag, ".bal"}, 64'(bal), 64'(eb));
    set_term(t, 1'b0, o, a);
    tick();
    chk({tag, ".idle"}, 64'({grant, busy, done}), 64'd0);
  endtask

  task automatic txn_hi(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [1:0] es, input logic [31:0] eb);
    req2[2]        = 1'b1;
    op2[5:4]       = o;
    amt2[47:32]    = a;
    tick();
    chk({tag, ".grant"}, 64'(grant2), 64'h4);
    tick();
    tick();
    chk({tag, ".done"}, 64'(done2), 64'd1);
    chk({tag, ".status"}, 64'(status2), 64'(es));
    chk({tag, ".bal"}, 64'(bal2), 64'(eb));
    req2[2] = 1'b0;
    tick();
    chk({tag, ".idle"}, 64'({grant2, busy2}), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_bal;
    logic [3:0]  exp_g;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    req    = '0;
    op     = '0;
    amt    = '0;
    req2   = '0;
    op2    = '0;
    amt2   = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst.grant", 64'(grant), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.status", 64'(status), 64'd0);
    chk("rst.bal", 64'(bal), 64'd1000000);
    chk("rst.bal_hi", 64'(bal2), 64'hFFFF_FFF0);

    // Deposit 500; winner changes inputs and drops req right after the grant
    set_term(0, 1'b1, 2'b10, 16'd500);
    tick();
    chk("dep.grant", 64'(grant), 64'h1);
    chk("dep.busy", 64'(busy), 64'd1);
    chk("dep.done_early", 64'(done), 64'd0);
    set_term(0, 1'b0, 2'b11, 16'd9999);
    tick();
    chk("dep.done_k1", 64'(done), 64'd0);
    tick();
    chk("dep.done", 64'(done), 64'd1);
    chk("dep.status", 64'(status), 64'd0);
    chk("dep.bal", 64'(bal), 64'd1000500);
    tick();
    chk("dep.done_off", 64'(done), 64'd0);
    chk("dep.grant_off", 64'(grant), 64'd0);
    chk("dep.busy_off", 64'(busy), 64'd0);
    chk("dep.bal_hold", 64'(bal), 64'd1000500);

    // Repeated withdraws down to exactly zero
    do_reset();
    exp_bal = 32'd1000000;
    for (int i = 0; i < 15; i++) begin
      exp_bal = exp_bal - 32'd65535;
      txn($sformatf("wdr%0d", i), 1, 2'b11, 16'hFFFF, 2'b00, exp_bal);
    end
    chk("wdr.final", 64'(bal), 64'd16975);
    txn("wdr.insuf", 1, 2'b11, 16'd16976, 2'b01, 32'd16975);
    txn("wdr.exact", 1, 2'b11, 16'd16975, 2'b00, 32'd0);
    txn("dep.zero", 1, 2'b10, 16'd0, 2'b00, 32'd0);
    txn("wdr.empty", 1, 2'b11, 16'd1, 2'b01, 32'd0);
    txn("inq", 3, 2'b01, 16'd77, 2'b00, 32'd0);

    // All four requesting: round-robin order, each drops req for one cycle after done
    do_reset();
    req = 4'b1111;
    op  = 8'b0101_0101;
    amt = '0;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'(1) << (i % 4);
      tick();
      chk($sformatf("rr%0d.grant", i), 64'(grant), 64'(exp_g));
      tick();
      chk($sformatf("rr%0d.onehot", i), 64'(grant), 64'(exp_g));
      tick();
      chk($sformatf("rr%0d.done", i), 64'(done), 64'd1);
      req[i % 4] = 1'b0;
      tick();
      chk($sformatf("rr%0d.release", i), 64'(grant), 64'd0);
      req[i % 4] = 1'b1;
    end
    req = '0;
    tick();
    tick();
    chk("rr.bal", 64'(bal), 64'd1000000);

    // Overflow boundary and illegal opcode
    txn_hi("ovf", 2'b10, 16'h0010, 2'b10, 32'hFFFF_FFF0);
    txn_hi("bad", 2'b00, 16'h0005, 2'b11, 32'hFFFF_FFF0);
    txn_hi("dep.max", 2'b10, 16'h000F, 2'b00, 32'hFFFF_FFFF);
    txn_hi("ovf1", 2'b10, 16'h0001, 2'b10, 32'hFFFF_FFFF);
    txn_hi("inq.hi", 2'b01, 16'h0000, 2'b00, 32'hFFFF_FFFF);

    // Reset before the commit edge aborts the deposit
    do_reset();
    set_term(0, 1'b1, 2'b10, 16'd500);
    tick();
    chk("abort.grant", 64'(grant), 64'h1);
    tick();
    reset = 1'b1;
    #1;
    chk("abort.grant_rst", 64'(grant), 64'd0);
    chk("abort.busy_rst", 64'(busy), 64'd0);
    chk("abort.bal_rst", 64'(bal), 64'd1000000);
    req = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort.done%0d", i), 64'(done), 64'd0);
    end
    chk("abort.bal", 64'(bal), 64'd1000000);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.grant_idle", 64'(grant), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
